// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge between the processor data port, dmem and the
// Pong peripherals: gated dmem writes, double-buffered display channels
// committed on frame start, a PS/2 scan-code FIFO and a frame counter.
module mmio_io_bridge #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int DMEM_LIMIT = 2000,
  parameter int IO_BASE    = 3000,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 10,
  parameter int KEY_DEPTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      proc_addr,
  input  logic [DATA_W-1:0]      proc_wdata,
  input  logic                   proc_wren,
  output logic [DATA_W-1:0]      proc_q,
  output logic                   dmem_wren,
  input  logic [DATA_W-1:0]      dmem_q,
  input  logic                   ps2_key_pressed,
  input  logic [7:0]             ps2_key_data,
  input  logic                   vga_vs,
  output logic [NUM_CH*CH_W-1:0] ch_live,
  output logic                   frame_pulse
);

  localparam int PTR_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] OFF_CTRL   = 32'(NUM_CH);
  localparam logic [31:0] OFF_KDATA  = 32'(NUM_CH + 1);
  localparam logic [31:0] OFF_KSTAT  = 32'(NUM_CH + 2);
  localparam logic [31:0] OFF_FRAME  = 32'(NUM_CH + 3);
  localparam logic [31:0] WIN_SIZE   = 32'(NUM_CH + 4);

  // State registers
  logic [CH_W-1:0]   shadow_q  [NUM_CH];
  logic [CH_W-1:0]   shadow_d  [NUM_CH];
  logic [CH_W-1:0]   ch_live_q [NUM_CH];
  logic [CH_W-1:0]   ch_live_d [NUM_CH];
  logic              imm_q, imm_d;
  logic              frc_q, frc_d;
  logic [7:0]        key_mem_q [KEY_DEPTH];
  logic [7:0]        key_mem_d [KEY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  key_cnt_q, key_cnt_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              vs_meta_q, vs_sync_q, vs_prev_q;
  logic              frame_pulse_q, frame_pulse_d;
  logic              sel_dmem_q, sel_dmem_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

  // Address decode
  logic [31:0] addr32;
  logic [31:0] off32;
  logic        is_dmem;
  logic        in_win;
  logic        io_wr;
  logic        key_empty;
  logic        key_full;
  logic        do_push;
  logic        do_pop;
  logic        ovf_set;
  logic        unused_wdata;

  assign addr32    = 32'(proc_addr);
  assign off32     = addr32 - 32'(IO_BASE);
  assign is_dmem   = addr32 < 32'(DMEM_LIMIT);
  assign in_win    = (addr32 >= 32'(IO_BASE)) && (off32 < WIN_SIZE);
  assign io_wr     = proc_wren && in_win;
  assign dmem_wren = proc_wren && is_dmem;
  assign unused_wdata = ^proc_wdata[DATA_W-1:CH_W];

  assign proc_q      = sel_dmem_q ? dmem_q : io_rdata_q;
  assign frame_pulse = frame_pulse_q;

  // Flatten committed channel values onto the output bus
  always_comb begin
    ch_live = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_live[i*CH_W +: CH_W] = ch_live_q[i];
    end
  end

  // Channel shadows, live values and CTRL: commit on frame or forced commit
  always_comb begin
    shadow_d  = shadow_q;
    ch_live_d = ch_live_q;
    imm_d     = imm_q;
    frc_d     = 1'b0;
    if (frame_pulse_q || frc_q) begin
      ch_live_d = shadow_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (io_wr && (off32 == 32'(i))) begin
        shadow_d[i] = proc_wdata[CH_W-1:0];
        if (imm_q) begin
          ch_live_d[i] = proc_wdata[CH_W-1:0];
        end
      end
    end
    if (io_wr && (off32 == OFF_CTRL)) begin
      imm_d = proc_wdata[0];
      frc_d = proc_wdata[1];
    end
  end

  // Key FIFO: a pop on a full FIFO makes room for a same-cycle push
  always_comb begin
    key_empty = (key_cnt_q == '0);
    key_full  = (key_cnt_q == CNT_W'(KEY_DEPTH));
    do_pop    = io_wr && (off32 == OFF_KDATA) && !key_empty;
    do_push   = ps2_key_pressed && (!key_full || do_pop);
    ovf_set   = ps2_key_pressed && key_full && !do_pop;
    key_mem_d = key_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push) begin
      key_mem_d[wr_ptr_q] = ps2_key_data;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    key_cnt_d = key_cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_d     = ovf_q;
    if (io_wr && (off32 == OFF_KSTAT)) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  // Frame start detect on the synchronized vsync and frame counting
  always_comb begin
    frame_pulse_d = vs_sync_q && !vs_prev_q;
    frame_cnt_d   = frame_cnt_q + 32'(frame_pulse_q);
  end

  // I/O read mux, captured together with the dmem/I-O select
  always_comb begin
    io_rdata_d = '0;
    sel_dmem_d = is_dmem;
    if (in_win) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (off32 == 32'(i)) begin
          io_rdata_d = DATA_W'(ch_live_q[i]);
        end
      end
      if (off32 == OFF_CTRL) begin
        io_rdata_d = DATA_W'(imm_q);
      end
      if (off32 == OFF_KDATA) begin
        io_rdata_d = key_empty ? '0 : DATA_W'(key_mem_q[rd_ptr_q]);
      end
      if (off32 == OFF_KSTAT) begin
        io_rdata_d = DATA_W'({ovf_q, 8'(key_cnt_q)});
      end
      if (off32 == OFF_FRAME) begin
        io_rdata_d = DATA_W'(frame_cnt_q);
      end
    end
  end

  // Control and channel state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i]  <= '0;
        ch_live_q[i] <= '0;
      end
      imm_q         <= 1'b0;
      frc_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      key_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      frame_cnt_q   <= '0;
      vs_meta_q     <= 1'b0;
      vs_sync_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      frame_pulse_q <= 1'b0;
      sel_dmem_q    <= 1'b0;
      io_rdata_q    <= '0;
    end else begin
      shadow_q      <= shadow_d;
      ch_live_q     <= ch_live_d;
      imm_q         <= imm_d;
      frc_q         <= frc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      key_cnt_q     <= key_cnt_d;
      ovf_q         <= ovf_d;
      frame_cnt_q   <= frame_cnt_d;
      vs_meta_q     <= vga_vs;
      vs_sync_q     <= vs_meta_q;
      vs_prev_q     <= vs_sync_q;
      frame_pulse_q <= frame_pulse_d;
      sel_dmem_q    <= sel_dmem_d;
      io_rdata_q    <= io_rdata_d;
    end
  end

  // Key storage needs no reset; the pointers and count define validity
  always_ff @(posedge clock) begin
    key_mem_q <= key_mem_d;
  end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Self-checking bench for mmio_io_bridge: directed steps with random data,
// compared against a behavioural model of channels, key FIFO and counters.
module tb_mmio_io_bridge;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DMEM_LIMIT = 2000;
  localparam int IO_BASE = 3000;
  localparam int NUM_CH = 4;
  localparam int CH_W = 10;
  localparam int KEY_DEPTH = 8;
  localparam int A_CTRL  = IO_BASE + NUM_CH;
  localparam int A_KDATA = IO_BASE + NUM_CH + 1;
  localparam int A_KSTAT = IO_BASE + NUM_CH + 2;
  localparam int A_FRAME = IO_BASE + NUM_CH + 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [ADDR_W-1:0]      proc_addr;
  logic [DATA_W-1:0]      proc_wdata;
  logic                   proc_wren;
  logic [DATA_W-1:0]      proc_q;
  logic                   dmem_wren;
  logic [DATA_W-1:0]      dmem_q;
  logic                   ps2_key_pressed;
  logic [7:0]             ps2_key_data;
  logic                   vga_vs;
  logic [NUM_CH*CH_W-1:0] ch_live;
  logic                   frame_pulse;

  mmio_io_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMEM_LIMIT(DMEM_LIMIT), .IO_BASE(IO_BASE),
    .NUM_CH(NUM_CH), .CH_W(CH_W), .KEY_DEPTH(KEY_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_wren(proc_wren), .proc_q(proc_q), .dmem_wren(dmem_wren), .dmem_q(dmem_q),
    .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data), .vga_vs(vga_vs),
    .ch_live(ch_live), .frame_pulse(frame_pulse)
  );

  always #5 clock = ~clock;

  // Registered dmem stand-in
  logic [DATA_W-1:0] dmem_arr [2048];
  always @(posedge clock) begin
    if (dmem_wren) dmem_arr[proc_addr[10:0]] <= proc_wdata;
    dmem_q <= dmem_arr[proc_addr[10:0]];
  end

  // Reference model
  logic [CH_W-1:0] m_shadow [NUM_CH];
  logic [CH_W-1:0] m_live   [NUM_CH];
  logic [7:0]      mq [$];
  bit              m_ovf;
  int              m_fcnt;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_live(input string tag);
    for (int i = 0; i < NUM_CH; i++) begin
      chk(tag, 32'(ch_live[i*CH_W +: CH_W]), 32'(m_live[i]));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    proc_addr = ADDR_W'(a);
    proc_wdata = d;
    proc_wren = 1'b1;
    tick();
    proc_wren = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] q);
    proc_addr = ADDR_W'(a);
    proc_wren = 1'b0;
    tick();
    q = proc_q;
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(m_ovf) << 8) | 32'(mq.size());
  endfunction

  function automatic logic [31:0] exp_head();
    return (mq.size() > 0) ? 32'(mq[0]) : 32'h0;
  endfunction

  // One cycle of key traffic: optional push, with mode 0 none, 1 pop, 2 clear overflow
  task automatic kcyc(input bit push, input logic [7:0] code, input int mode);
    bit p;
    bit full;
    bit set;
    ps2_key_pressed = push;
    ps2_key_data = code;
    proc_wdata = 32'h0;
    proc_wren = (mode != 0);
    proc_addr = ADDR_W'((mode == 1) ? A_KDATA : A_KSTAT);
    tick();
    ps2_key_pressed = 1'b0;
    proc_wren = 1'b0;
    p = (mode == 1) && (mq.size() > 0);
    full = (mq.size() == KEY_DEPTH);
    set = 1'b0;
    if (p) void'(mq.pop_front());
    if (push) begin
      if (!full || p) mq.push_back(code);
      else set = 1'b1;
    end
    if (mode == 2) m_ovf = 1'b0;
    if (set) m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = '0;
      m_live[i] = '0;
    end
    mq.delete();
    m_ovf = 1'b0;
    m_fcnt = 0;
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] v;
    int ra;
    for (int i = 0; i < 2048; i++) dmem_arr[i] = '0;
    reset = 1'b1;
    proc_addr = '0;
    proc_wdata = '0;
    proc_wren = 1'b0;
    ps2_key_pressed = 1'b0;
    ps2_key_data = '0;
    vga_vs = 1'b0;
    model_reset();
    repeat (3) tick();

    // Reset state
    chk_live("reset_live");
    chk("reset_pulse", 32'(frame_pulse), 32'h0);
    chk("reset_proc_q", proc_q, 32'h0);
    chk("reset_dmem_wren", 32'(dmem_wren), 32'h0);
    reset = 1'b0;

    // dmem write gating at the limit
    proc_addr = ADDR_W'(DMEM_LIMIT - 1);
    proc_wdata = 32'd5;
    proc_wren = 1'b1;
    #1;
    chk("dmem_wren_1999", 32'(dmem_wren), 32'h1);
    tick();
    proc_addr = ADDR_W'(DMEM_LIMIT);
    #1;
    chk("dmem_wren_2000", 32'(dmem_wren), 32'h0);
    tick();
    proc_wren = 1'b0;
    ra = $urandom_range(0, DMEM_LIMIT - 2);
    v = $urandom;
    wr(ra, v);
    rd(DMEM_LIMIT - 1, q);
    chk("load_1999", q, 32'd5);
    rd(DMEM_LIMIT, q);
    chk("load_2000", q, 32'h0);
    rd(ra, q);
    chk("load_rand_dmem", q, v);
    rd(2500, q);
    chk("load_gap", q, 32'h0);
    rd(A_FRAME + 1, q);
    chk("load_past_window", q, 32'h0);

    // Shadow writes wait for the frame commit
    for (int i = 0; i < NUM_CH; i++) begin
      v = (i == 0) ? 32'd320 : $urandom;
      wr(IO_BASE + i, v);
      m_shadow[i] = v[CH_W-1:0];
    end
    chk_live("live_before_frame");
    rd(IO_BASE, q);
    chk("read_ch0_before_frame", q, 32'(m_live[0]));
    vga_vs = 1'b1;
    tick();
    chk("pulse_edge1", 32'(frame_pulse), 32'h0);
    tick();
    chk("pulse_edge2", 32'(frame_pulse), 32'h0);
    tick();
    chk("pulse_edge3", 32'(frame_pulse), 32'h1);
    chk_live("live_at_pulse");
    tick();
    for (int i = 0; i < NUM_CH; i++) m_live[i] = m_shadow[i];
    m_fcnt++;
    chk("pulse_edge4", 32'(frame_pulse), 32'h0);
    chk_live("live_after_frame");
    vga_vs = 1'b0;
    rd(A_FRAME, q);
    chk("frame_cnt", q, 32'(m_fcnt));
    rd(IO_BASE, q);
    chk("read_ch0_after_frame", q, 32'd320);

    // Forced commit and immediate mode
    v = $urandom;
    wr(IO_BASE + 2, v);
    m_shadow[2] = v[CH_W-1:0];
    wr(A_CTRL, 32'h3);
    chk_live("live_before_force");
    tick();
    for (int i = 0; i < NUM_CH; i++) m_live[i] = m_shadow[i];
    chk_live("live_after_force");
    rd(A_CTRL, q);
    chk("ctrl_imm", q, 32'h1);
    wr(IO_BASE + 1, 32'd77);
    m_shadow[1] = 10'd77;
    m_live[1] = 10'd77;
    chk_live("live_imm_write");
    rd(IO_BASE + 1, q);
    chk("read_ch1_imm", q, 32'd77);
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, q);
    chk("ctrl_cleared", q, 32'h0);

    // Key FIFO overflow, ordering and simultaneous push/pop
    for (int k = 0; k < 9; k++) kcyc(1'b1, 8'(8'h1C + k), 0);
    rd(A_KSTAT, q);
    chk("kstat_overflow", q, exp_status());
    rd(A_KDATA, q);
    chk("kdata_head", q, exp_head());
    kcyc(1'b0, 8'h00, 1);
    rd(A_KDATA, q);
    chk("kdata_after_pop", q, exp_head());
    kcyc(1'b1, 8'h60, 0);
    kcyc(1'b1, 8'h55, 1);
    rd(A_KSTAT, q);
    chk("kstat_full_push_pop", q, exp_status());
    kcyc(1'b0, 8'h00, 2);
    rd(A_KSTAT, q);
    chk("kstat_cleared", q, exp_status());
    kcyc(1'b0, 8'h00, 1);
    rd(A_KSTAT, q);
    chk("kstat_after_pop", q, exp_status());
    kcyc(1'b1, 8'($urandom), 0);
    kcyc(1'b1, 8'($urandom), 2);
    rd(A_KSTAT, q);
    chk("kstat_set_beats_clear", q, exp_status());
    kcyc(1'b0, 8'h00, 2);
    for (int k = 0; k < KEY_DEPTH; k++) begin
      rd(A_KDATA, q);
      chk("kdata_drain", q, exp_head());
      kcyc(1'b0, 8'h00, 1);
    end
    rd(A_KDATA, q);
    chk("kdata_empty", q, exp_head());
    kcyc(1'b0, 8'h00, 1);
    rd(A_KSTAT, q);
    chk("kstat_empty_pop", q, exp_status());
    kcyc(1'b1, 8'h42, 1);
    rd(A_KSTAT, q);
    chk("kstat_empty_push_pop", q, exp_status());
    rd(A_KDATA, q);
    chk("kdata_empty_push_pop", q, exp_head());
    for (int k = 0; k < 12; k++) begin
      kcyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 1));
    end
    rd(A_KSTAT, q);
    chk("kstat_random", q, exp_status());
    rd(A_KDATA, q);
    chk("kdata_random", q, exp_head());

    // Reset mid-operation discards the pending commit and push
    v = $urandom;
    wr(IO_BASE, v);
    wr(A_CTRL, 32'h2);
    reset = 1'b1;
    ps2_key_pressed = 1'b1;
    ps2_key_data = 8'hAA;
    tick();
    reset = 1'b0;
    ps2_key_pressed = 1'b0;
    model_reset();
    chk_live("live_in_reset");
    chk("proc_q_in_reset", proc_q, 32'h0);
    tick();
    chk_live("live_after_reset");
    rd(A_KSTAT, q);
    chk("kstat_after_reset", q, exp_status());
    rd(A_FRAME, q);
    chk("frame_after_reset", q, 32'(m_fcnt));
    rd(IO_BASE, q);
    chk("ch0_after_reset", q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
